lsu_ctrl: RTL

Load/store sequencer between the RV32 core's memory stage and the byte-addressed data memory. Accepts one load or store request at a time, and converts RISC-V byte/halfword/word accesses into the memory's whole-word read and write. Sub-word stores use read-modify-write, because the memory always writes 4 bytes. Loads are sign- or zero-extended. Responses return through a valid pulse, so the core stalls while `req_ready` is low.

---
 rtl/lsu_ctrl_if.sv | 27 ++
 rtl/lsu_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory signal bundle for lsu_ctrl.
// slave is the sequencer's view; master is the core-plus-memory side.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: RV32 byte/half/word accesses onto a whole-word memory, sub-word
// stores by read-modify-write. Optional feature macro: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);

    // Every access touches 4 bytes, so the last legal start address is MEM_BYTES-4.
    localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_ready;
    logic        accept;
    logic        misalign;
    logic        req_err;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {{24{w[7] & ~f3[2]}}, w[7:0]};
            2'b01:   r = {{16{w[15] & ~f3[2]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [31:0] old,
                                                input logic [31:0] wd);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {old[31:8], wd[7:0]};
            2'b01:   r = {old[31:16], wd[15:0]};
            default: r = wd;
        endcase
        return r;
    endfunction

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (bus.req_funct3[1:0] == 2'b01) begin
            misalign = bus.req_addr[0];
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            misalign = |bus.req_addr[1:0];
        end
`endif
        req_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                  (bus.req_we && bus.req_funct3[2]) ||
                  (bus.req_addr > MaxAddr) || misalign;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        old_d       = old_q;
        f3_d        = f3_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    f3_d    = bus.req_funct3;
                    we_d    = bus.req_we;
                    if (req_err) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                old_d = bus.mem_rdata;
                if (we_q) begin
                    state_d = StWrite;
                end else begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_ext(f3_q, bus.mem_rdata);
                end
            end
            StWrite: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            old_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            old_q       <= old_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = addr_q;
    // Built only from registers, so it is stable across the falling-edge write.
    assign bus.mem_wdata = store_merge(f3_q, old_q, wdata_q);
    assign bus.mem_we    = (state_q == StWrite) && !rst;

endmodule
